// File: rtl/img_host_pkg.sv
// img_host_pkg: shared image geometry and read-FSM state type
package img_host_pkg;
  localparam int IMG_AW = 14;
  localparam int IMG_DW = 8;
  localparam int IMG_DEPTH = 16384;
  typedef enum logic [1:0] {IDLE, READ, WAIT, RESP} rd_state_e;
endpackage

// File: rtl/img_host_responder_if.sv
// img_host_responder_if: imgproc/SRAM-facing bus of the host responder
interface img_host_responder_if import img_host_pkg::*; ();
  logic request;
  logic [IMG_AW-1:0] orig_addr;
  logic [IMG_DW-1:0] orig_data;
  logic orig_ready;
  logic mem_rd;
  logic [IMG_AW-1:0] mem_addr;
  logic [IMG_DW-1:0] mem_rdata;
  logic imgproc_ready;
  logic [IMG_AW-1:0] imgproc_addr;
  logic [IMG_DW-1:0] imgproc_data;
  logic finish;
  logic res_we;
  logic [IMG_AW-1:0] res_addr;
  logic [IMG_DW-1:0] res_wdata;
  logic [IMG_AW:0] wr_cnt;
  logic done;
  modport slave(
    input request, orig_addr, mem_rdata, imgproc_ready, imgproc_addr, imgproc_data, finish,
    output orig_data, orig_ready, mem_rd, mem_addr, res_we, res_addr, res_wdata, wr_cnt, done
  );
  modport master(
    output request, orig_addr, mem_rdata, imgproc_ready, imgproc_addr, imgproc_data, finish,
    input orig_data, orig_ready, mem_rd, mem_addr, res_we, res_addr, res_wdata, wr_cnt, done
  );
endinterface

// File: rtl/img_res_sink.sv
// img_res_sink: registers result writes, counts commits, flags completion
module img_res_sink import img_host_pkg::*; #(
  parameter int DEPTH = IMG_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              imgproc_ready,
  input  logic [IMG_AW-1:0] imgproc_addr,
  input  logic [IMG_DW-1:0] imgproc_data,
  input  logic              finish,
  output logic              res_we,
  output logic [IMG_AW-1:0] res_addr,
  output logic [IMG_DW-1:0] res_wdata,
  output logic [IMG_AW:0]   wr_cnt,
  output logic              done
);
  logic res_we_d, res_we_q, done_d, done_q;
  logic [IMG_AW-1:0] res_addr_d, res_addr_q;
  logic [IMG_DW-1:0] res_wdata_d, res_wdata_q;
  logic [IMG_AW:0] wr_cnt_d, wr_cnt_q;
  // next write beat, saturating commit count and sticky completion
  always_comb begin
    res_we_d = imgproc_ready;
    res_addr_d = imgproc_ready ? imgproc_addr : res_addr_q;
    res_wdata_d = imgproc_ready ? imgproc_data : res_wdata_q;
    wr_cnt_d = (imgproc_ready && wr_cnt_q < (IMG_AW+1)'(DEPTH)) ? wr_cnt_q + 1'b1 : wr_cnt_q;
    done_d = done_q | finish;
  end
  // write-path registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_we_q <= 1'b0;
      res_addr_q <= '0;
      res_wdata_q <= '0;
      wr_cnt_q <= '0;
      done_q <= 1'b0;
    end else begin
      res_we_q <= res_we_d;
      res_addr_q <= res_addr_d;
      res_wdata_q <= res_wdata_d;
      wr_cnt_q <= wr_cnt_d;
      done_q <= done_d;
    end
  end
  assign res_we = res_we_q;
  assign res_addr = res_addr_q;
  assign res_wdata = res_wdata_q;
  assign wr_cnt = wr_cnt_q;
  assign done = done_q;
endmodule

// File: rtl/img_host_responder.sv
// img_host_responder: serves imgproc source-pixel reads and forwards result writes
module img_host_responder import img_host_pkg::*; #(
  parameter int RD_LAT = 1,
  parameter int DEPTH = IMG_DEPTH
) (
  input logic clk,
  input logic rst,
  img_host_responder_if.slave bus
);
  rd_state_e state_d, state_q;
  logic [1:0] cnt_d, cnt_q;
  logic orig_ready_d, orig_ready_q, mem_rd_d, mem_rd_q;
  logic [IMG_DW-1:0] orig_data_d, orig_data_q;
  logic [IMG_AW-1:0] mem_addr_d, mem_addr_q;
  // read FSM: one SRAM strobe per request, response once the read latency has elapsed
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    orig_data_d = orig_data_q;
    orig_ready_d = 1'b0;
    mem_rd_d = 1'b0;
    mem_addr_d = '0;
    case (state_q)
      IDLE: if (bus.request) begin
        state_d = READ;
        mem_rd_d = 1'b1;
        mem_addr_d = bus.orig_addr;
      end
      READ: begin
        state_d = RD_LAT == 1 ? RESP : WAIT;
        cnt_d = '0;
      end
      WAIT: begin
        state_d = cnt_q == 2'(RD_LAT - 2) ? RESP : WAIT;
        cnt_d = cnt_q + 1'b1;
      end
      RESP: begin
        state_d = IDLE;
        orig_ready_d = 1'b1;
        orig_data_d = bus.mem_rdata;
      end
      default: state_d = IDLE;
    endcase
  end
  // read-path registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      orig_data_q <= '0;
      orig_ready_q <= 1'b0;
      mem_rd_q <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      orig_data_q <= orig_data_d;
      orig_ready_q <= orig_ready_d;
      mem_rd_q <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
    end
  end
  assign bus.orig_data = orig_data_q;
  assign bus.orig_ready = orig_ready_q;
  assign bus.mem_rd = mem_rd_q;
  assign bus.mem_addr = mem_addr_q;
  img_res_sink #(.DEPTH(DEPTH)) u_sink (
    .clk(clk),
    .rst(rst),
    .imgproc_ready(bus.imgproc_ready),
    .imgproc_addr(bus.imgproc_addr),
    .imgproc_data(bus.imgproc_data),
    .finish(bus.finish),
    .res_we(bus.res_we),
    .res_addr(bus.res_addr),
    .res_wdata(bus.res_wdata),
    .wr_cnt(bus.wr_cnt),
    .done(bus.done)
  );
endmodule

// File: tb/tb_img_host_responder.sv
// tb_img_host_responder: RD_LAT=1 and RD_LAT=3 responders checked against a timing-rule model
module tb_img_host_responder;
  localparam int DEPTH = 16384;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic request = 1'b0, imgproc_ready = 1'b0, finish = 1'b0;
  logic [13:0] orig_addr = '0, imgproc_addr = '0;
  logic [7:0] imgproc_data = '0;
  logic [7:0] mem [DEPTH];
  logic [7:0] p1;
  logic [7:0] p3 [3];
  img_host_responder_if b1 ();
  img_host_responder_if b3 ();
  img_host_responder #(.RD_LAT(1)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));
  img_host_responder #(.RD_LAT(3)) u3 (.clk(clk), .rst(rst), .bus(b3.slave));
  assign b1.request = request;
  assign b3.request = request;
  assign b1.orig_addr = orig_addr;
  assign b3.orig_addr = orig_addr;
  assign b1.imgproc_ready = imgproc_ready;
  assign b3.imgproc_ready = imgproc_ready;
  assign b1.imgproc_addr = imgproc_addr;
  assign b3.imgproc_addr = imgproc_addr;
  assign b1.imgproc_data = imgproc_data;
  assign b3.imgproc_data = imgproc_data;
  assign b1.finish = finish;
  assign b3.finish = finish;
  assign b1.mem_rdata = p1;
  assign b3.mem_rdata = p3[2];
  always @(posedge clk) begin
    if (b1.mem_rd) p1 <= mem[b1.mem_addr];
    if (b3.mem_rd) p3[0] <= mem[b3.mem_addr];
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  logic [23:0] obs_rd [2];
  logic [38:0] obs_wr [2];
  assign obs_rd[0] = {b1.orig_ready, b1.orig_data, b1.mem_rd, b1.mem_addr};
  assign obs_rd[1] = {b3.orig_ready, b3.orig_data, b3.mem_rd, b3.mem_addr};
  assign obs_wr[0] = {b1.res_we, b1.res_addr, b1.res_wdata, b1.wr_cnt, b1.done};
  assign obs_wr[1] = {b3.res_we, b3.res_addr, b3.res_wdata, b3.wr_cnt, b3.done};
  int checks = 0, errors = 0, cyc = 0, we_seen = 0;
  int ready_at [2], free_at [2];
  logic [13:0] pend [2], e_maddr [2];
  logic [7:0] e_odat [2];
  logic e_rdy [2], e_mrd [2];
  logic e_we, e_done;
  logic [13:0] e_wa;
  logic [7:0] e_wd;
  int e_cnt;
  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      ready_at[k] = -1;
      free_at[k] = 0;
      e_rdy[k] = 1'b0;
      e_odat[k] = '0;
      e_mrd[k] = 1'b0;
      e_maddr[k] = '0;
    end
    e_we = 1'b0;
    e_wa = '0;
    e_wd = '0;
    e_cnt = 0;
    e_done = 1'b0;
  endtask
  task automatic check();
    logic [23:0] er;
    logic [38:0] ew;
    ew = {e_we, e_wa, e_wd, 15'(e_cnt), e_done};
    for (int k = 0; k < 2; k++) begin
      er = {e_rdy[k], e_odat[k], e_mrd[k], e_maddr[k]};
      checks++;
      assert (obs_rd[k] === er) else begin
        errors++;
        $error("FAIL rd_L%0d cyc=%0d got=%h exp=%h", k ? 3 : 1, cyc, obs_rd[k], er);
      end
      checks++;
      assert (obs_wr[k] === ew) else begin
        errors++;
        $error("FAIL wr_L%0d cyc=%0d got=%h exp=%h", k ? 3 : 1, cyc, obs_wr[k], ew);
      end
    end
    we_seen += int'(b1.res_we);
  endtask
  // one clock: drive inputs, apply the edge to the model, then compare
  task automatic step(input logic r, input logic [13:0] a, input logic w,
                      input logic [13:0] wa, input logic [7:0] wd, input logic f);
    request = r;
    orig_addr = a;
    imgproc_ready = w;
    imgproc_addr = wa;
    imgproc_data = wd;
    finish = f;
    @(posedge clk);
    cyc++;
    if (rst) model_reset();
    else begin
      for (int k = 0; k < 2; k++) begin
        e_rdy[k] = (cyc == ready_at[k]);
        if (e_rdy[k]) e_odat[k] = mem[pend[k]];
        e_mrd[k] = 1'b0;
        e_maddr[k] = '0;
        if (r && cyc >= free_at[k]) begin
          e_mrd[k] = 1'b1;
          e_maddr[k] = a;
          pend[k] = a;
          ready_at[k] = cyc + (k ? 3 : 1) + 1;
          free_at[k] = cyc + (k ? 3 : 1) + 2;
        end
      end
      e_we = w;
      if (w) begin
        e_wa = wa;
        e_wd = wd;
        if (e_cnt < DEPTH) e_cnt++;
      end
      e_done = e_done | f;
    end
    #1;
    check();
  endtask
  task automatic idle(input int n);
    repeat (n) step(1'b0, '0, 1'b0, '0, '0, 1'b0);
  endtask
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
    mem[5] = 8'hA7;
    model_reset();
    #2;
    check();
    idle(2);
    rst = 1'b0;
    step(1'b1, 14'h0005, 1'b0, '0, '0, 1'b0);
    idle(6);
    repeat (10) step(1'b1, 14'h3FFF, 1'b0, '0, '0, 1'b0);
    idle(6);
    we_seen = 0;
    for (int i = 0; i < 100; i++)
      step(1'($urandom_range(0, 1)), 14'($urandom), 1'b1, 14'(i), 8'($urandom), 1'b0);
    idle(1);
    checks++;
    assert (we_seen === 100) else begin errors++; $error("FAIL we_cycles got=%0d exp=100", we_seen); end
    checks++;
    assert (b3.wr_cnt === 15'd100) else begin errors++; $error("FAIL wr_cnt100 got=%0d exp=100", b3.wr_cnt); end
    repeat (300)
      step(1'($urandom_range(0, 1)), 14'($urandom), 1'($urandom_range(0, 1)), 14'($urandom), 8'($urandom), 1'b0);
    step(1'b0, '0, 1'b1, 14'h3FFF, 8'h11, 1'b1);
    idle(4);
    checks++;
    assert (b1.done === 1'b1 && b3.done === 1'b1) else begin errors++; $error("FAIL done_sticky got=%b%b exp=11", b1.done, b3.done); end
    step(1'b1, 14'($urandom), 1'b0, '0, '0, 1'b0);
    idle(1);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check();
    idle(2);
    rst = 1'b0;
    idle(5);
    step(1'b1, 14'($urandom), 1'b0, '0, '0, 1'b0);
    idle(6);
    for (int i = 0; i < DEPTH + 2; i++)
      step(1'($urandom_range(0, 1)), 14'($urandom), 1'b1, 14'(i), 8'($urandom), 1'b0);
    idle(1);
    checks++;
    assert (b1.wr_cnt === 15'd16384 && b3.wr_cnt === 15'd16384) else begin
      errors++;
      $error("FAIL wr_cnt_sat got=%0d/%0d exp=16384", b1.wr_cnt, b3.wr_cnt);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
